atlantic_packetizer: RTL and testbench
======================================

ATLANTIC_PACKETIZER -- requirements
Module: atlantic_packetizer

Interface
REQ-001 Parameter DATA_WIDTH, default 16, sample width in bits.
REQ-002 Parameter FIFO_DEPTH, default 16, buffer depth in words, power of two, at least 4.
REQ-003 Parameter NUM_CH, default 2, channel count for round-robin packet tagging, at least 1.
REQ-004 Parameter LEN_W, default 9, width of the packet-length input.
REQ-005 Port clk, input, 1, single clock; all logic on its rising edge.
REQ-006 Port rst, input, 1, reset, asynchronous and active-low.
REQ-007 Port in_valid, input, 1, upstream sample valid.
REQ-008 Port in_data, input, DATA_WIDTH, upstream sample.
REQ-009 Port in_ready, output, 1, buffer can accept a sample.
REQ-010 Port pkt_len, input, LEN_W, beats per packet; sampled on the SOP beat only.
REQ-011 Port dav_o, output, 1, buffer holds at least one full packet (count >= latched or current pkt_len).
REQ-012 Port val_o, output, 1, dat_o is valid (buffer non-empty).
REQ-013 Port ena_o, input, 1, sink enable; a beat transfers when val_o and ena_o are both 1.
REQ-014 Port sop_o / eop_o, output, 1 each, first and last beat of a packet.
REQ-015 Port dat_o, output, DATA_WIDTH, head-of-buffer sample.
REQ-016 Port ch_o, output, clog2(NUM_CH) (minimum 1), channel tag of the current packet.
REQ-017 Port err_o, output, 1, underrun flag (see Configuration).

Function
REQ-018 Push occurs when in_valid=1 and in_ready=1; in_ready = not full.
REQ-019 A sample pushed in cycle N SHALL be visible on dat_o with val_o=1 in cycle N+1 when the buffer was empty.
REQ-020 Simultaneous push and pop SHALL keep the count unchanged; a pop while empty SHALL be ignored; a push while full is impossible by construction.
REQ-021 FSM states: IDLE (waiting for first beat), BODY (mid-packet).
REQ-022 IDLE: sop_o = val_o; a transfer latches pkt_len into len_q, sets beat_cnt=1, and goes to BODY, or stays in IDLE if len_q <= 1.
REQ-023 BODY: each transfer increments beat_cnt; eop_o = val_o and (beat_cnt == len_q-1); the eop transfer returns the FSM to IDLE.
REQ-024 pkt_len=0 SHALL be treated as 1; pkt_len=1 SHALL assert sop_o and eop_o on the same beat.
REQ-025 ch_o SHALL be constant within a packet and advance modulo NUM_CH after each eop transfer; it wraps from NUM_CH-1 to 0.
REQ-026 Changes to pkt_len mid-packet SHALL have no effect until the next SOP.
REQ-027 Buffer pointers wrap modulo FIFO_DEPTH; count width = clog2(FIFO_DEPTH)+1.

Reset
REQ-028 Assertion of rst SHALL immediately clear the buffer and set FSM=IDLE, beat_cnt=0, len_q=1, ch_o=0, err_o=0; val_o, dav_o, sop_o, eop_o=0 and in_ready=1 while in reset.
REQ-029 Reset mid-packet SHALL discard the partial packet; the next beat after release SHALL be an SOP on channel 0.
REQ-030 Reset release SHALL be synchronised internally (two-flop) before it gates pushes or pops.

Configuration
REQ-031 With macro ATLANTIC_PKT_ERR_CHECK_EN defined: in BODY, ena_o=1 with val_o=0 SHALL set err_o sticky until the next SOP transfer.
REQ-032 Without ATLANTIC_PKT_ERR_CHECK_EN: err_o SHALL be tied to 0 and no detection logic SHALL be present.

Structure
REQ-033 Package atlantic_pkg SHALL hold the FSM state enum, a clog2 helper and default parameter constants.
REQ-034 Storage SHALL be the sub-module sync_fifo (depth, width parameters; push/pop/full/empty/count).

Verification
REQ-035 NUM_CH=2, pkt_len=4, push 8 samples 1..8, ena_o=1 -> sop on 1 and 5, eop on 4 and 8, ch_o 0 then 1.
REQ-036 pkt_len=1, push 3 samples -> three beats, each with sop=eop=1, ch_o sequence 0,1,0.
REQ-037 FIFO_DEPTH=16, ena_o=0, push 20 -> in_ready=0 after 16 pushes; one pop -> in_ready=1 the next cycle.
REQ-038 pkt_len=8, 3 samples pushed, ena_o=1 -> dav_o=0; with ERR_CHECK_EN, err_o=1 after the third beat, cleared on the next SOP.
REQ-039 rst pulsed low after beat 2 of a 4-beat packet -> all outputs 0; the next push yields sop_o=1, ch_o=0.
REQ-040 pkt_len changed from 4 to 2 on beat 2 -> current packet still ends on beat 4; the next packet has 2 beats.

Source files
------------

// File: rtl/atlantic_pkg.sv
// Shared types and defaults for the Atlantic packetizer: FSM state enum,
// default parameter values and a constant-foldable clog2 helper.
`timescale 1ns/1ps
package atlantic_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BODY = 1'b1
    } pkt_state_e;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_FIFO_DEPTH = 16;
    localparam int DEF_NUM_CH     = 2;
    localparam int DEF_LEN_W      = 9;

    // Smallest r with (1 << r) >= value; 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data; pointers wrap
// modulo DEPTH (power of two). Push while full and pop while empty are ignored.
`timescale 1ns/1ps
module sync_fifo
    import atlantic_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int WIDTH = DEF_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_push,
    input  logic [WIDTH-1:0]        i_data,
    input  logic                    i_pop,
    output logic [WIDTH-1:0]        o_data,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [clog2(DEPTH):0]   o_count
);
    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/atlantic_packetizer.sv
// Buffers a sample stream and frames it into fixed-length Atlantic packets
// with SOP/EOP and round-robin channel tags. Optional underrun flag: ATLANTIC_PKT_ERR_CHECK_EN.
`timescale 1ns/1ps
module atlantic_packetizer
    import atlantic_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int LEN_W      = DEF_LEN_W,
    localparam int CH_W      = (NUM_CH > 1) ? clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic [LEN_W-1:0]      pkt_len,
    output logic                  dav_o,
    output logic                  val_o,
    input  logic                  ena_o,
    output logic                  sop_o,
    output logic                  eop_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic [CH_W-1:0]       ch_o,
    output logic                  err_o,
    output logic                  o_dbg_state
);
    // Handshakes: a push happens on a rising edge where in_valid & in_ready;
    // a beat leaves on a rising edge where val_o & ena_o. Neither side waits
    // for the other combinationally beyond these two products.
    localparam int CW    = clog2(FIFO_DEPTH) + 1;
    localparam int CMP_W = (LEN_W > CW) ? LEN_W : CW;

    logic [1:0]       r_rst_sync;
    logic             w_run;
    logic             w_full;
    logic             w_empty;
    logic [CW-1:0]    w_count;
    logic             w_push;
    logic             w_xfer;
    logic [LEN_W-1:0] w_eff_len;
    logic [LEN_W-1:0] w_need_len;
    pkt_state_e       r_state;
    pkt_state_e       w_next_state;
    logic [LEN_W-1:0] r_len_q;
    logic [LEN_W-1:0] r_beat_cnt;
    logic [CH_W-1:0]  r_ch;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_rst_sync <= 2'b00;
        else      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_run = r_rst_sync[1];

    // Ready is held low during the synchroniser window so no sample is dropped.
    assign in_ready = ~w_full & (w_run | ~rst);
    assign w_push   = in_valid & in_ready & w_run;
    assign val_o    = ~w_empty;
    assign w_xfer   = val_o & ena_o & w_run;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .i_push  (w_push),
        .i_data  (in_data),
        .i_pop   (w_xfer),
        .o_data  (dat_o),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_eff_len = (pkt_len == '0) ? LEN_W'(1) : pkt_len;

    always_comb begin
        w_next_state = r_state;
        sop_o        = 1'b0;
        eop_o        = 1'b0;
        w_need_len   = r_len_q;
        case (r_state)
            ST_IDLE: begin
                sop_o      = val_o;
                eop_o      = val_o & (w_eff_len == LEN_W'(1));
                w_need_len = w_eff_len;
                if (w_xfer && (w_eff_len > LEN_W'(1))) w_next_state = ST_BODY;
            end
            ST_BODY: begin
                eop_o = val_o & (r_beat_cnt == (r_len_q - LEN_W'(1)));
                if (w_xfer && eop_o) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_len_q    <= LEN_W'(1);
            r_beat_cnt <= '0;
            r_ch       <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_xfer) begin
                if (r_state == ST_IDLE) begin
                    r_len_q    <= w_eff_len;
                    r_beat_cnt <= LEN_W'(1);
                end else begin
                    r_beat_cnt <= r_beat_cnt + LEN_W'(1);
                end
                if (eop_o) r_ch <= (r_ch == CH_W'(NUM_CH - 1)) ? '0 : r_ch + CH_W'(1);
            end
        end
    end

    assign dav_o       = CMP_W'(w_count) >= CMP_W'(w_need_len);
    assign ch_o        = r_ch;
    assign o_dbg_state = r_state;

`ifdef ATLANTIC_PKT_ERR_CHECK_EN
    logic r_err;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                              r_err <= 1'b0;
        else if (w_xfer && r_state == ST_IDLE)                 r_err <= 1'b0;
        else if (r_state == ST_BODY && ena_o && !val_o && w_run) r_err <= 1'b1;
    end
    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_atlantic_packetizer.sv
// Randomised and directed bench for atlantic_packetizer against a queue-based
// packet-framing model; honours ATLANTIC_PKT_ERR_CHECK_EN when defined.
`timescale 1ns/1ps
module tb_atlantic_packetizer;
    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int NCH   = 2;
    localparam int LW    = 9;
`ifdef ATLANTIC_PKT_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic [LW-1:0] pkt_len = LW'(4);
    logic          dav_o, val_o, sop_o, eop_o, err_o, dbg_state;
    logic          ena_o = 1'b0;
    logic [DW-1:0] dat_o;
    logic [0:0]    ch_o;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [DW-1:0] exp_q[$];
    int m_pos, m_cur_len, m_ch, m_run_cnt;
    bit m_err;

    atlantic_packetizer #(
        .DATA_WIDTH (DW), .FIFO_DEPTH (DEPTH), .NUM_CH (NCH), .LEN_W (LW)
    ) dut (
        .clk (clk), .rst (rst), .in_valid (in_valid), .in_data (in_data),
        .in_ready (in_ready), .pkt_len (pkt_len), .dav_o (dav_o), .val_o (val_o),
        .ena_o (ena_o), .sop_o (sop_o), .eop_o (eop_o), .dat_o (dat_o),
        .ch_o (ch_o), .err_o (err_o), .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, obs, exp);
        end
    endtask

    // One clock: drive at the falling edge, compare, then advance the model at the rising edge.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic e, input logic [LW-1:0] len);
        bit m_run, e_val, e_ready, e_sop, e_eop, e_dav, push, pop;
        int eff, need, pos0;
        in_valid = v; in_data = d; ena_o = e; pkt_len = len;
        #1;
        m_run   = (m_run_cnt >= 2);
        e_val   = (exp_q.size() > 0);
        e_ready = (exp_q.size() < DEPTH) && m_run;
        eff     = (len == 0) ? 1 : int'(len);
        need    = (m_pos == 0) ? eff : m_cur_len;
        e_sop   = e_val && (m_pos == 0);
        e_eop   = e_val && ((m_pos == 0) ? (eff == 1) : (m_pos == m_cur_len - 1));
        e_dav   = (exp_q.size() >= need);
        check("in_ready", 32'(in_ready), 32'(e_ready));
        check("val_o",    32'(val_o),    32'(e_val));
        check("sop_o",    32'(sop_o),    32'(e_sop));
        check("eop_o",    32'(eop_o),    32'(e_eop));
        check("dav_o",    32'(dav_o),    32'(e_dav));
        check("ch_o",     32'(ch_o),     32'(m_ch));
        check("err_o",    32'(err_o),    32'(m_err));
        if (e_val) check("dat_o", 32'(dat_o), 32'(exp_q[0]));
        push = v && e_ready;
        pop  = e_val && e && m_run;
        pos0 = m_pos;
        @(posedge clk);
        if (pop) begin
            void'(exp_q.pop_front());
            if (m_pos == 0) m_cur_len = eff;
            if (m_pos == m_cur_len - 1) begin
                m_pos = 0;
                m_ch  = (m_ch + 1) % NCH;
            end else begin
                m_pos++;
            end
        end
        if (ERR_EN) begin
            if (pop && pos0 == 0) m_err = 1'b0;
            else if (pos0 != 0 && e && !e_val && m_run) m_err = 1'b1;
        end
        if (push) exp_q.push_back(d);
        if (m_run_cnt < 2) m_run_cnt++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0; in_valid = 1'b0; ena_o = 1'b0;
        #1;
        check("rst_val",   32'(val_o),    0);
        check("rst_dav",   32'(dav_o),    0);
        check("rst_sop",   32'(sop_o),    0);
        check("rst_eop",   32'(eop_o),    0);
        check("rst_ready", 32'(in_ready), 1);
        check("rst_ch",    32'(ch_o),     0);
        check("rst_err",   32'(err_o),    0);
        exp_q.delete();
        m_pos = 0; m_cur_len = 1; m_ch = 0; m_err = 1'b0; m_run_cnt = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic idle(input int n, input logic e, input logic [LW-1:0] len);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, e, len);
    endtask

    initial begin
        logic [LW-1:0] rlen;
        @(negedge clk);
        do_reset();
        idle(2, 1'b0, 4);

        // two 4-beat packets of samples 1..8
        for (int i = 1; i <= 8; i++) cycle(1'b1, DW'(i), 1'b1, 4);
        idle(4, 1'b1, 4);

        // single-beat packets
        do_reset(); idle(2, 1'b0, 1);
        for (int i = 1; i <= 3; i++) cycle(1'b1, DW'(16'h10 + i), 1'b1, 1);
        idle(3, 1'b1, 1);

        // fill to full, one pop re-opens ready
        do_reset(); idle(2, 1'b0, 4);
        for (int i = 0; i < 20; i++) cycle(1'b1, DW'(16'h100 + i), 1'b0, 4);
        cycle(1'b0, '0, 1'b1, 4);
        cycle(1'b1, DW'(16'h200), 1'b0, 4);
        idle(20, 1'b1, 4);

        // short packet: underrun mid-packet, cleared on the next SOP
        do_reset(); idle(2, 1'b0, 8);
        for (int i = 0; i < 3; i++) cycle(1'b1, DW'(16'h300 + i), 1'b1, 8);
        idle(3, 1'b1, 8);
        for (int i = 3; i < 9; i++) cycle(1'b1, DW'(16'h300 + i), 1'b1, 8);
        idle(3, 1'b1, 8);

        // reset in the middle of a 4-beat packet
        do_reset(); idle(2, 1'b0, 4);
        for (int i = 0; i < 2; i++) cycle(1'b1, DW'(16'h400 + i), 1'b1, 4);
        idle(1, 1'b1, 4);
        do_reset(); idle(2, 1'b0, 4);
        cycle(1'b1, DW'(16'h4AA), 1'b1, 4);
        idle(2, 1'b1, 4);

        // pkt_len change mid-packet only applies from the next SOP
        do_reset(); idle(2, 1'b0, 4);
        cycle(1'b1, DW'(16'h500), 1'b1, 4);
        for (int i = 1; i < 6; i++) cycle(1'b1, DW'(16'h500 + i), 1'b1, 2);
        idle(3, 1'b1, 2);

        // random traffic with wandering pkt_len and back-pressure phases
        rlen = LW'(3);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) rlen = LW'($urandom_range(0, 6));
            if (i == 700) begin
                do_reset(); idle(2, 1'b0, rlen);
            end
            cycle(($urandom_range(0, 99) < 70), DW'($urandom),
                  ($urandom_range(0, 99) < ((i % 300 < 100) ? 20 : 65)), rlen);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
